// File: rtl/seg7_pkg.sv
// Seven-segment code table shared by the display encoder and the scan decoder.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

  typedef logic [6:0] seg_code_t;
  typedef logic [3:0] digit_t;

  localparam seg_code_t SEG_0     = 7'h3F;
  localparam seg_code_t SEG_1     = 7'h06;
  localparam seg_code_t SEG_2     = 7'h5B;
  localparam seg_code_t SEG_3     = 7'h4F;
  localparam seg_code_t SEG_4     = 7'h66;
  localparam seg_code_t SEG_5     = 7'h6D;
  localparam seg_code_t SEG_6     = 7'h7D;
  localparam seg_code_t SEG_7     = 7'h07;
  localparam seg_code_t SEG_8     = 7'h7F;
  localparam seg_code_t SEG_9     = 7'h6F;
  localparam seg_code_t SEG_BLANK = 7'h00;

  localparam digit_t DIG_BLANK = 4'hF;
  localparam digit_t DIG_ERR   = 4'hE;

  // Numbers outside 0..9 encode to a dark digit.
  function automatic seg_code_t seg7_encode(input digit_t num);
    seg_code_t code;
    case (num)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  // Exact-match inverse of seg7_encode; blank is legal, anything unlisted is an error.
  function automatic digit_t seg7_decode(input seg_code_t code);
    digit_t num;
    num = DIG_ERR;
    if (code == SEG_BLANK) num = DIG_BLANK;
    for (int i = 0; i < 10; i++) begin
      if (code == seg7_encode(4'(i))) num = 4'(i);
    end
    return num;
  endfunction

endpackage

// File: rtl/seg_sync_filter.sv
// Synchronises an asynchronous bus and emits a single capture pulse once the
// synchronised value has been stable for STABLE_CYCLES consecutive samples.
module seg_sync_filter #(
  parameter int unsigned WIDTH         = 11,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             cap
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);
  localparam logic [CntW-1:0] CntCap = CntW'(STABLE_CYCLES - 1);

  localparam logic [0:0] ST_SETTLE = 1'b0;
  localparam logic [0:0] ST_HELD   = 1'b1;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  prev_q;
  logic [CntW-1:0]                   cnt_q, cnt_d;
  logic                              same;
  logic [0:0]                        state;

  assign dout  = sync_q[SYNC_STAGES-1];
  assign same  = (dout == prev_q);
  assign state = (cnt_q == CntMax) ? ST_HELD : ST_SETTLE;

  always_comb begin
    cnt_d = cnt_q;
    if (!same) begin
      cnt_d = '0;
    end else if (state == ST_SETTLE) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Fires on the last settling sample only, so one pulse per stable period.
  assign cap = same && (state == ST_SETTLE) && (cnt_q == CntCap);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= dout;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/segment_scan_decoder.sv
// Receive side of the seven-segment path: filters the multiplexed bus, decodes each
// strobed digit and publishes complete frames as packed BCD.
module segment_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS      = 4,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic [N_DIGITS-1:0]   dig_in,
  output logic [4*N_DIGITS-1:0] bcd_out,
  output logic                  frame_valid,
  output logic                  code_err,
  output logic                  sel_err
);

  localparam int unsigned W = N_DIGITS + 7;

  logic [W-1:0]          s;
  logic                  cap;
  seg_code_t             cap_seg;
  logic [N_DIGITS-1:0]   cap_dig;
  digit_t                dec;
  logic                  one_hot;
  logic                  wr;

  logic [N_DIGITS-1:0][3:0] slot_q, slot_d;
  logic [N_DIGITS-1:0]      mask_q, mask_d;
  logic [4*N_DIGITS-1:0]    bcd_q, bcd_d;
  logic                     fv_q, fv_d;
  logic                     ce_q, ce_d;
  logic                     se_q, se_d;

  seg_sync_filter #(
    .WIDTH         (W),
    .STABLE_CYCLES (STABLE_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({dig_in, seg_in}),
    .dout  (s),
    .cap   (cap)
  );

  assign cap_seg = s[6:0];
  assign cap_dig = s[W-1:7];
  assign one_hot = $onehot(cap_dig);
  assign dec     = seg7_decode(cap_seg);
  assign wr      = cap && one_hot;

  // A zero strobe field is the blanking interval and is silently ignored.
  assign se_d = cap && (cap_dig != '0) && !one_hot;
  assign ce_d = wr && (dec == DIG_ERR);

  always_comb begin
    slot_d = slot_q;
    mask_d = mask_q;
    bcd_d  = bcd_q;
    fv_d   = 1'b0;
    if (wr) begin
      for (int i = 0; i < int'(N_DIGITS); i++) begin
        if (cap_dig[i]) slot_d[i] = dec;
      end
      mask_d = mask_q | cap_dig;
      // Publish including the digit being written this cycle.
      if (&mask_d) begin
        bcd_d  = slot_d;
        mask_d = '0;
        fv_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
      mask_q <= '0;
      bcd_q  <= {N_DIGITS{DIG_BLANK}};
      fv_q   <= 1'b0;
      ce_q   <= 1'b0;
      se_q   <= 1'b0;
    end else begin
      slot_q <= slot_d;
      mask_q <= mask_d;
      bcd_q  <= bcd_d;
      fv_q   <= fv_d;
      ce_q   <= ce_d;
      se_q   <= se_d;
    end
  end

  assign bcd_out     = bcd_q;
  assign frame_valid = fv_q;
  assign code_err    = ce_q;
  assign sel_err     = se_q;

endmodule
